mem_unit: RTL and testbench

//  Memory subsystem directly downstream of cpu: consumes its mem_* request bus and returns read data.

---
 rtl/mem_unit_pkg.sv | 57 +++++
 rtl/mem_unit_if.sv | 22 ++
 rtl/mem_unit_uart_tx.sv | 107 ++++++++++
 rtl/mem_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_unit_pkg.sv
// rtl/mem_unit_pkg.sv - shared types, address map and lane helpers for mem_unit
package mem_unit_pkg;

    typedef enum logic [1:0] {
        UNIT_BYTE = 2'd0,
        UNIT_HALF = 2'd1,
        UNIT_WORD = 2'd2,
        UNIT_BAD  = 2'd3
    } mem_unit_t;

    typedef enum logic [2:0] {
        TGT_NONE,
        TGT_RAM,
        TGT_MTIME_LO,
        TGT_MTIME_HI,
        TGT_MTIMECMP_LO,
        TGT_MTIMECMP_HI,
        TGT_UART
    } mem_tgt_t;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    localparam logic [31:0] MTIMECMP_LO = 32'h0200_4000;
    localparam logic [31:0] MTIMECMP_HI = 32'h0200_4004;
    localparam logic [31:0] MTIME_LO    = 32'h0200_BFF8;
    localparam logic [31:0] MTIME_HI    = 32'h0200_BFFC;
    localparam logic [31:0] UART_BASE   = 32'h1000_0000;

    // Move the addressed lane down to bit 0 and clear everything above the unit.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input mem_unit_t unit,
                                                 input logic [1:0] off);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (unit)
            UNIT_BYTE: return {24'b0, s[7:0]};
            UNIT_HALF: return {16'b0, s[15:0]};
            default:   return s;
        endcase
    endfunction

    // Byte-enable mask for a store of the given unit at the given byte offset.
    function automatic logic [3:0] lane_enable(input mem_unit_t unit,
                                               input logic [1:0] off);
        case (unit)
            UNIT_BYTE: return 4'b0001 << off;
            UNIT_HALF: return 4'b0011 << off;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_unit_if.sv
// rtl/mem_unit_if.sv - cpu to mem_unit request/response bus
interface mem_unit_if;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [1:0]  mem_rd_unit;
    logic [1:0]  mem_wd_unit;
    logic [31:0] mem_rd;
    logic        access_fault;
    logic        addr_misaligned;

    modport master (
        output mem_re, mem_we, mem_addr, mem_wd, mem_rd_unit, mem_wd_unit,
        input  mem_rd, access_fault, addr_misaligned
    );

    modport slave (
        input  mem_re, mem_we, mem_addr, mem_wd, mem_rd_unit, mem_wd_unit,
        output mem_rd, access_fault, addr_misaligned
    );
endinterface

// File: rtl/mem_unit_uart_tx.sv
// rtl/mem_unit_uart_tx.sv - TX FIFO and 8N1 serializer, built only with MEM_UART_EN
`ifdef MEM_UART_EN
module mem_unit_uart_tx
    import mem_unit_pkg::*;
#(
    parameter int DIV   = 868,
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] data,
    output logic       full,
    output logic       tx
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);

    logic [7:0]    fifo [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          empty;
    logic          pop;
    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic          bit_end;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop     = (state == U_IDLE) && !empty;
    assign bit_end = (cnt == BIT_LAST);

    // FIFO storage; pushes into a full FIFO are silently dropped.
    always_ff @(posedge clk) begin
        if (push && !full) fifo[wr_ptr[PW-1:0]] <= data;
    end

    // FIFO pointers advance on accepted push and on serializer pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop)           rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Frame FSM: start bit, 8 data bits LSB first, stop bit, each DIV clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= U_IDLE;
            tx      <= 1'b1;
            cnt     <= '0;
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                U_IDLE: begin
                    cnt <= '0;
                    if (!empty) begin
                        shreg <= fifo[rd_ptr[PW-1:0]];
                        tx    <= 1'b0;
                        state <= U_START;
                    end
                end
                U_START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        tx      <= shreg[0];
                        bit_idx <= '0;
                        state   <= U_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                U_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= U_STOP;
                        end else begin
                            tx      <= shreg[1];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= U_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
`endif

// File: rtl/mem_unit.sv
// rtl/mem_unit.sv - RAM + CLINT timer MMIO decode for the cpu; optional UART TX under MEM_UART_EN
module mem_unit
    import mem_unit_pkg::*;
#(
    parameter int RAM_AW    = 12,
    parameter     INIT_FILE = ""
`ifdef MEM_UART_EN
    ,
    parameter int UART_DIV   = 868,
    parameter int UART_DEPTH = 8
`endif
) (
    input  logic        clk,
    input  logic        reset,
    mem_unit_if.slave   bus,
    input  logic [63:0] mtime,
    input  logic [63:0] mtimecmp,
    output logic [63:0] mtime_next,
    output logic [63:0] mtimecmp_next,
`ifdef MEM_UART_EN
    output logic        uart_tx,
`endif
    output logic        mtime_we
);
    logic [31:0]     ram [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;
    logic            active;
    mem_unit_t       unit;
    logic [1:0]      off;
    mem_tgt_t        tgt;
    logic            mmio;
    logic            misaligned;
    logic            fault_raw;
    logic            rd_ok;
    logic            wr_ok;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [31:0]     mmio_val;
    logic [31:0]     ram_q;
    logic [31:0]     mmio_q;
    logic            src_ram;
    mem_unit_t       rd_unit_q;
    logic [1:0]      rd_off_q;
`ifdef MEM_UART_EN
    logic            uart_full;
`endif

    assign active  = bus.mem_re || bus.mem_we;
    assign unit    = bus.mem_we ? mem_unit_t'(bus.mem_wd_unit) : mem_unit_t'(bus.mem_rd_unit);
    assign off     = bus.mem_addr[1:0];
    assign ram_idx = bus.mem_addr[RAM_AW+1:2];

    // Address decode: RAM window from 0, then exact-word MMIO registers.
    always_comb begin
        tgt = TGT_NONE;
        if (bus.mem_addr[31:RAM_AW+2] == '0)  tgt = TGT_RAM;
        else if (bus.mem_addr == MTIME_LO)    tgt = TGT_MTIME_LO;
        else if (bus.mem_addr == MTIME_HI)    tgt = TGT_MTIME_HI;
        else if (bus.mem_addr == MTIMECMP_LO) tgt = TGT_MTIMECMP_LO;
        else if (bus.mem_addr == MTIMECMP_HI) tgt = TGT_MTIMECMP_HI;
`ifdef MEM_UART_EN
        else if (bus.mem_addr == UART_BASE)   tgt = TGT_UART;
`endif
    end

    assign mmio = (tgt == TGT_MTIME_LO) || (tgt == TGT_MTIME_HI) ||
                  (tgt == TGT_MTIMECMP_LO) || (tgt == TGT_MTIMECMP_HI);

    // Misalignment is checked first and masks every fault cause.
    assign misaligned = active && (((unit == UNIT_HALF) && off[0]) ||
                                   ((unit == UNIT_WORD) && (off != 2'b00)));
    assign fault_raw  = active && ((tgt == TGT_NONE) || (unit == UNIT_BAD) ||
                                   (mmio && (unit != UNIT_WORD)) ||
                                   (bus.mem_re && bus.mem_we));

    assign bus.addr_misaligned = !reset && misaligned;
    assign bus.access_fault    = !reset && fault_raw && !misaligned;

    assign rd_ok = !reset && bus.mem_re && !misaligned && !fault_raw;
    assign wr_ok = !reset && bus.mem_we && !misaligned && !fault_raw;

    assign be    = lane_enable(unit, off);
    assign wdata = (unit == UNIT_BYTE) ? {4{bus.mem_wd[7:0]}} :
                   (unit == UNIT_HALF) ? {2{bus.mem_wd[15:0]}} : bus.mem_wd;

    // RAM array with per-byte write enables.
    always_ff @(posedge clk) begin
        if (wr_ok && (tgt == TGT_RAM)) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram[ram_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Synchronous RAM read port; output register holds until the next accepted RAM read.
    always_ff @(posedge clk) begin
        if (reset)                          ram_q <= '0;
        else if (rd_ok && (tgt == TGT_RAM)) ram_q <= ram[ram_idx];
    end

    // MMIO value as seen in the request cycle.
    always_comb begin
        mmio_val = '0;
        case (tgt)
            TGT_MTIME_LO:    mmio_val = mtime[31:0];
            TGT_MTIME_HI:    mmio_val = mtime[63:32];
            TGT_MTIMECMP_LO: mmio_val = mtimecmp[31:0];
            TGT_MTIMECMP_HI: mmio_val = mtimecmp[63:32];
`ifdef MEM_UART_EN
            TGT_UART:        mmio_val = {31'b0, uart_full};
`endif
            default:         mmio_val = '0;
        endcase
    end

    // Capture source, size and offset of each accepted read for next-cycle steering.
    always_ff @(posedge clk) begin
        if (reset) begin
            mmio_q    <= '0;
            src_ram   <= 1'b0;
            rd_unit_q <= UNIT_WORD;
            rd_off_q  <= 2'b00;
        end else if (rd_ok) begin
            mmio_q    <= mmio_val;
            src_ram   <= (tgt == TGT_RAM);
            rd_unit_q <= unit;
            rd_off_q  <= off;
        end
    end

    assign bus.mem_rd = lane_extract(src_ram ? ram_q : mmio_q, rd_unit_q, rd_off_q);

    // Timer writes are combinational replacements of one 32-bit half.
    always_comb begin
        mtime_we      = 1'b0;
        mtime_next    = mtime;
        mtimecmp_next = mtimecmp;
        if (wr_ok) begin
            case (tgt)
                TGT_MTIME_LO: begin
                    mtime_we   = 1'b1;
                    mtime_next = {mtime[63:32], bus.mem_wd};
                end
                TGT_MTIME_HI: begin
                    mtime_we   = 1'b1;
                    mtime_next = {bus.mem_wd, mtime[31:0]};
                end
                TGT_MTIMECMP_LO: mtimecmp_next = {mtimecmp[63:32], bus.mem_wd};
                TGT_MTIMECMP_HI: mtimecmp_next = {bus.mem_wd, mtimecmp[31:0]};
                default: ;
            endcase
        end
    end

`ifdef MEM_UART_EN
    mem_unit_uart_tx #(
        .DIV   (UART_DIV),
        .DEPTH (UART_DEPTH)
    ) u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .push  (wr_ok && (tgt == TGT_UART)),
        .data  (bus.mem_wd[7:0]),
        .full  (uart_full),
        .tx    (uart_tx)
    );
`endif
endmodule

// File: tb/tb_mem_unit.sv
// tb/tb_mem_unit.sv - vector-table bench for mem_unit
module tb_mem_unit;
    import mem_unit_pkg::*;

    localparam logic [63:0] MT = 64'h0000_0005_0000_0010;
    localparam logic [63:0] MC = 64'h0000_0007_0000_0001;

    typedef struct {
        bit          re;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  unit;
        logic [31:0] e_rd;
        bit          e_fault;
        bit          e_mis;
        bit          e_mwe;
        logic [63:0] e_mtn;
        logic [63:0] e_mcn;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [63:0] mtime_next;
    logic [63:0] mtimecmp_next;
    logic        mtime_we;
`ifdef MEM_UART_EN
    logic        uart_tx;
`endif
    int          checks;
    int          errors;
    vec_t        v[$];

    mem_unit_if bus ();

    mem_unit #(
        .RAM_AW (12)
`ifdef MEM_UART_EN
        , .UART_DIV (4)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .mtime         (mtime),
        .mtimecmp      (mtimecmp),
        .mtime_next    (mtime_next),
        .mtimecmp_next (mtimecmp_next),
`ifdef MEM_UART_EN
        .uart_tx       (uart_tx),
`endif
        .mtime_we      (mtime_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit re, input bit we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [1:0] unit,
                                input logic [31:0] e_rd, input bit e_fault, input bit e_mis,
                                input bit e_mwe, input logic [63:0] e_mtn,
                                input logic [63:0] e_mcn);
        vec_t r;
        r.re = re; r.we = we; r.addr = addr; r.wd = wd; r.unit = unit;
        r.e_rd = e_rd; r.e_fault = e_fault; r.e_mis = e_mis; r.e_mwe = e_mwe;
        r.e_mtn = e_mtn; r.e_mcn = e_mcn;
        return r;
    endfunction

    task automatic drive(input bit re, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] unit);
        bus.mem_re      = re;
        bus.mem_we      = we;
        bus.mem_addr    = addr;
        bus.mem_wd      = wd;
        bus.mem_rd_unit = unit;
        bus.mem_wd_unit = unit;
    endtask

    initial begin
        logic [31:0] uart_rd;
        logic [31:0] uart_flt;
        logic [9:0]  frame;
        bit          seen;
        checks = 0;
        errors = 0;
`ifdef MEM_UART_EN
        uart_rd  = 32'h0;
        uart_flt = 32'h0;
`else
        uart_rd  = 32'hCAFE_F00D;
        uart_flt = 32'h1;
`endif

        //        re we addr          wd            u  e_rd          flt mis mwe e_mtn                   e_mcn
        v.push_back(mk(0,1,32'h0000_0100,32'hDEAD_BEEF,2,32'h0000_0000,0,0,0,MT,MC));
        v.push_back(mk(1,0,32'h0000_0103,32'h0,        0,32'h0000_00DE,0,0,0,MT,MC));
        v.push_back(mk(0,1,32'h0000_0102,32'h0000_1234,1,32'h0000_00DE,0,0,0,MT,MC));
        v.push_back(mk(1,0,32'h0000_0100,32'h0,        2,32'h1234_BEEF,0,0,0,MT,MC));
        v.push_back(mk(1,0,32'h0000_0101,32'h0,        1,32'h1234_BEEF,0,1,0,MT,MC));
        v.push_back(mk(1,0,32'h0000_0100,32'h0,        2,32'h1234_BEEF,0,0,0,MT,MC));
        v.push_back(mk(1,0,32'h0000_0102,32'h0,        1,32'h0000_1234,0,0,0,MT,MC));
        v.push_back(mk(1,0,32'h0000_0100,32'h0,        0,32'h0000_00EF,0,0,0,MT,MC));
        v.push_back(mk(0,1,32'h0000_0101,32'h0000_00A5,0,32'h0000_00EF,0,0,0,MT,MC));
        v.push_back(mk(1,0,32'h0000_0100,32'h0,        2,32'h1234_A5EF,0,0,0,MT,MC));
        v.push_back(mk(0,1,32'h0200_BFF8,32'hFFFF_0000,2,32'h1234_A5EF,0,0,1,64'h0000_0005_FFFF_0000,MC));
        v.push_back(mk(0,1,32'h0200_BFFC,32'h0000_00AB,2,32'h1234_A5EF,0,0,1,64'h0000_00AB_0000_0010,MC));
        v.push_back(mk(0,1,32'h0200_4004,32'h0,        2,32'h1234_A5EF,0,0,0,MT,64'h0000_0000_0000_0001));
        v.push_back(mk(0,0,32'h0200_4004,32'h0,        2,32'h1234_A5EF,0,0,0,MT,MC));
        v.push_back(mk(0,1,32'h0200_4000,32'h1234_5678,2,32'h1234_A5EF,0,0,0,MT,64'h0000_0007_1234_5678));
        v.push_back(mk(1,0,32'h0200_4000,32'h0,        2,32'h0000_0001,0,0,0,MT,MC));
        v.push_back(mk(1,0,32'h0200_BFFC,32'h0,        2,32'h0000_0005,0,0,0,MT,MC));
        v.push_back(mk(1,0,32'h0200_BFF8,32'h0,        2,32'h0000_0010,0,0,0,MT,MC));
        v.push_back(mk(1,0,32'h3000_0000,32'h0,        2,32'h0000_0010,1,0,0,MT,MC));
        v.push_back(mk(0,1,32'h0200_4000,32'h0000_00FF,0,32'h0000_0010,1,0,0,MT,MC));
        v.push_back(mk(1,0,32'h0000_0100,32'h0,        3,32'h0000_0010,1,0,0,MT,MC));
        v.push_back(mk(1,1,32'h0000_0100,32'hFFFF_FFFF,2,32'h0000_0010,1,0,0,MT,MC));
        v.push_back(mk(1,0,32'h0000_0100,32'h0,        2,32'h1234_A5EF,0,0,0,MT,MC));
        v.push_back(mk(0,1,32'h0000_0102,32'h5555_5555,2,32'h1234_A5EF,0,1,0,MT,MC));
        v.push_back(mk(1,0,32'h3000_0002,32'h0,        2,32'h1234_A5EF,0,1,0,MT,MC));
        v.push_back(mk(1,0,32'h0000_0100,32'h0,        2,32'h1234_A5EF,0,0,0,MT,MC));
        v.push_back(mk(0,1,32'h0000_3FFC,32'hCAFE_F00D,2,32'h1234_A5EF,0,0,0,MT,MC));
        v.push_back(mk(1,0,32'h0000_3FFC,32'h0,        2,32'hCAFE_F00D,0,0,0,MT,MC));
        v.push_back(mk(1,0,32'h0000_4000,32'h0,        2,32'hCAFE_F00D,1,0,0,MT,MC));
        v.push_back(mk(1,0,32'h1000_0000,32'h0,        2,uart_rd,uart_flt[0],0,0,MT,MC));
        v.push_back(mk(1,0,32'h0200_BFF8,32'h0,        1,uart_rd,1,0,0,MT,MC));
        v.push_back(mk(1,0,32'h0000_3FFE,32'h0,        1,32'h0000_CAFE,0,0,0,MT,MC));

        // Reset state
        reset    = 1'b1;
        mtime    = MT;
        mtimecmp = MC;
        drive(0, 0, 32'h0, 32'h0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset mem_rd", bus.mem_rd, 32'h0);
        chk("reset mtime_we", mtime_we, 0);
        chk("reset access_fault", bus.access_fault, 0);
        chk("reset addr_misaligned", bus.addr_misaligned, 0);
        chk("reset mtimecmp_next", mtimecmp_next, MC);
`ifdef MEM_UART_EN
        chk("reset uart_tx", uart_tx, 1);
`endif
        reset = 1'b0;

        // Table vectors: combinational outputs in the request cycle, mem_rd one cycle later
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i].re, v[i].we, v[i].addr, v[i].wd, v[i].unit);
            #2;
            chk($sformatf("v%0d access_fault", i), bus.access_fault, v[i].e_fault);
            chk($sformatf("v%0d addr_misaligned", i), bus.addr_misaligned, v[i].e_mis);
            chk($sformatf("v%0d mtime_we", i), mtime_we, v[i].e_mwe);
            if (v[i].e_mwe) chk($sformatf("v%0d mtime_next", i), mtime_next, v[i].e_mtn);
            chk($sformatf("v%0d mtimecmp_next", i), mtimecmp_next, v[i].e_mcn);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d mem_rd", i), bus.mem_rd, v[i].e_rd);
        end

        // Reset mid-transfer: read request and timer write presented during reset
        drive(1, 0, 32'h0000_0100, 32'h0, 2'd2);
        reset = 1'b1;
        #2;
        chk("rst-mid access_fault", bus.access_fault, 0);
        @(posedge clk);
        #1;
        chk("rst-mid mem_rd", bus.mem_rd, 32'h0);
        drive(0, 1, 32'h0200_BFF8, 32'h1111_1111, 2'd2);
        #2;
        chk("rst-mid mtime_we", mtime_we, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1, 0, 32'h0000_0100, 32'h0, 2'd2);
        @(posedge clk);
        #1;
        chk("post-reset ram keeps data", bus.mem_rd, 32'h1234_A5EF);
        drive(0, 0, 32'h0, 32'h0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("idle holds mem_rd", bus.mem_rd, 32'h1234_A5EF);

`ifdef MEM_UART_EN
        // UART frame for 0x55, each bit held 4 clocks
        drive(0, 1, UART_BASE, 32'h0000_0055, 2'd0);
        @(posedge clk);
        #1;
        drive(0, 0, 32'h0, 32'h0, 2'd0);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (uart_tx == 1'b0) seen = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("uart start seen", seen, 1);
        if (seen) begin
            frame = 10'b1010101010;
            repeat (2) @(posedge clk);
            #1;
            for (int b = 0; b < 10; b++) begin
                chk($sformatf("uart bit%0d", b), uart_tx, frame[b]);
                repeat (4) @(posedge clk);
                #1;
            end
            chk("uart idle after frame", uart_tx, 1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
